// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and PC constants for the fetch sequencer
package fetch_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] PC_STEP = 16'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BOOT = 2'd1,
        REQ  = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/REGISTER.sv
// rtl/REGISTER.sv - plain enable-load register with no reset
module REGISTER #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] data,
    input  logic             EN,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk) begin
        if (EN) begin
            out <= data;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer driving the PC/IR registers
// Optional fetch/discard counters are built when FETCH_PERF_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            branch_valid,
    input  logic [PC_W-1:0] branch_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] pc_data,
    output logic            pc_en,
    output logic [PC_W-1:0] ir_data,
    output logic            ir_en
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]     fetch_count,
    output logic [15:0]     discard_count
`endif
);

    fetch_state_t    state, state_nxt;
    logic            branch_pend;
    logic [PC_W-1:0] pend_target;
    logic [PC_W-1:0] hold_q;
    logic            ack_in_req;
    logic            redirect;
    logic [PC_W-1:0] redirect_target;
    logic            hold_en;

    // A branch arriving with the ack is newer than any pending one.
    assign ack_in_req      = (state == REQ) && imem_ack;
    assign redirect        = branch_pend || branch_valid;
    assign redirect_target = branch_valid ? branch_target : pend_target;
    assign hold_en         = ack_in_req && !redirect && stall;

    REGISTER #(.WIDTH(PC_W)) u_hold (
        .clk  (clk),
        .data (imem_rdata),
        .EN   (hold_en),
        .out  (hold_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_pend <= 1'b0;
            pend_target <= '0;
        end else if (state == REQ) begin
            if (imem_ack) begin
                branch_pend <= 1'b0;
            end else if (branch_valid) begin
                branch_pend <= 1'b1;
                pend_target <= branch_target;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = '0;
        pc_en     = 1'b0;
        pc_data   = '0;
        ir_en     = 1'b0;
        ir_data   = '0;
        case (state)
            IDLE: state_nxt = BOOT;
            BOOT: begin
                pc_en     = 1'b1;
                pc_data   = RESET_VECTOR;
                state_nxt = REQ;
            end
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (imem_ack) begin
                    if (redirect) begin
                        pc_en   = 1'b1;
                        pc_data = redirect_target;
                    end else if (stall) begin
                        state_nxt = HOLD;
                    end else begin
                        ir_en   = 1'b1;
                        ir_data = imem_rdata;
                        pc_en   = 1'b1;
                        pc_data = pc + PC_STEP;
                    end
                end
            end
            HOLD: begin
                if (branch_valid) begin
                    pc_en     = 1'b1;
                    pc_data   = branch_target;
                    state_nxt = REQ;
                end else if (!stall) begin
                    ir_en     = 1'b1;
                    ir_data   = hold_q;
                    pc_en     = 1'b1;
                    pc_data   = pc + PC_STEP;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FETCH_PERF_EN
    logic discard_evt;

    // A word dropped from the hold buffer by a branch was acked too.
    assign discard_evt = (ack_in_req && redirect) || ((state == HOLD) && branch_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count   <= '0;
            discard_count <= '0;
        end else begin
            if (ir_en && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (discard_evt && (discard_count != 16'hFFFF)) begin
                discard_count <= discard_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_reg = 16'h0000;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] pc_data;
    logic        pc_en;
    logic [15:0] ir_data;
    logic        ir_en;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] discard_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_VECTOR(16'h0100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc_reg),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_data       (pc_data),
        .pc_en         (pc_en),
        .ir_data       (ir_data),
        .ir_en         (ir_en)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count),
        .discard_count (discard_count)
`endif
    );

    always #5 clk = ~clk;

    // Environment model of the PC REGISTER the controller drives.
    always @(posedge clk) begin
        if (pc_en) pc_reg <= pc_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic s, input logic bv, input logic [15:0] bt,
                         input logic a, input logic [15:0] rd);
        @(negedge clk);
        stall = s; branch_valid = bv; branch_target = bt; imem_ack = a; imem_rdata = rd;
        #1;
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b1, 16'h7777, 1'b0, 16'h0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc_en got %b exp 0", pc_en); end
        checks++; if (ir_en !== 1'b0) begin errors++; $display("FAIL rst_ir_en got %b exp 0", ir_en); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if ({imem_req, pc_en, ir_en} !== 3'b000) begin errors++; $display("FAIL idle_out got %b exp 000", {imem_req, pc_en, ir_en}); end
        drive(1'b0, 1'b1, 16'h5555, 1'b0, 16'h0);
        checks++; if (pc_en !== 1'b1 || pc_data !== 16'h0100) begin errors++; $display("FAIL boot_pc got en=%b data=%h exp en=1 data=0100", pc_en, pc_data); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", imem_req); end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0100", imem_req, imem_addr); end
    endtask

    task automatic test_zero_wait;
        logic [15:0] rd;
        for (int k = 0; k < 4; k++) begin
            rd = 16'($urandom);
            drive(1'b0, 1'b0, 16'h0, 1'b1, rd);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100 + 16'(k)) begin errors++; $display("FAIL zw_addr got req=%b addr=%h exp addr=%h", imem_req, imem_addr, 16'h0100 + 16'(k)); end
            checks++; if (ir_en !== 1'b1 || ir_data !== rd) begin errors++; $display("FAIL zw_ir got en=%b data=%h exp en=1 data=%h", ir_en, ir_data, rd); end
            checks++; if (pc_en !== 1'b1 || pc_data !== 16'h0101 + 16'(k)) begin errors++; $display("FAIL zw_pc got en=%b data=%h exp %h", pc_en, pc_data, 16'h0101 + 16'(k)); end
        end
    endtask

    task automatic test_wait3;
        for (int w = 0; w < 3; w++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b0, 16'($urandom));
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0104) begin errors++; $display("FAIL wait_stable got req=%b addr=%h exp req=1 addr=0104", imem_req, imem_addr); end
            checks++; if (ir_en !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL wait_no_en got ir=%b pc=%b exp 0 0", ir_en, pc_en); end
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1, 16'hA5A5);
        checks++; if (ir_en !== 1'b1 || ir_data !== 16'hA5A5 || imem_addr !== 16'h0104) begin errors++; $display("FAIL wait_ack got ir=%b data=%h addr=%h exp 1 a5a5 0104", ir_en, ir_data, imem_addr); end
    endtask

    task automatic test_stall;
        drive(1'b1, 1'b0, 16'h0, 1'b1, 16'hBEEF);
        checks++; if (ir_en !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL stall_ack got ir=%b pc=%b exp 0 0", ir_en, pc_en); end
        for (int h = 0; h < 4; h++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            checks++; if ({imem_req, ir_en, pc_en} !== 3'b000) begin errors++; $display("FAIL hold_quiet got %b exp 000", {imem_req, ir_en, pc_en}); end
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (ir_en !== 1'b1 || ir_data !== 16'hBEEF) begin errors++; $display("FAIL hold_release got en=%b data=%h exp 1 beef", ir_en, ir_data); end
        checks++; if (pc_en !== 1'b1 || pc_data !== 16'h0106) begin errors++; $display("FAIL hold_pc got en=%b data=%h exp 1 0106", pc_en, pc_data); end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0106) begin errors++; $display("FAIL hold_next got req=%b addr=%h exp 1 0106", imem_req, imem_addr); end
    endtask

    task automatic test_branch;
        drive(1'b0, 1'b1, 16'h0010, 1'b1, 16'h1111);
        checks++; if (ir_en !== 1'b0 || pc_data !== 16'h0010) begin errors++; $display("FAIL br_setup got ir=%b pc=%h exp 0 0010", ir_en, pc_data); end
        drive(1'b0, 1'b1, 16'h2000, 1'b0, 16'h0);
        checks++; if (imem_addr !== 16'h0010 || pc_en !== 1'b0) begin errors++; $display("FAIL br_pend got addr=%h pc_en=%b exp 0010 0", imem_addr, pc_en); end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin errors++; $display("FAIL br_stable got req=%b addr=%h exp 1 0010", imem_req, imem_addr); end
        drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
        checks++; if (ir_en !== 1'b0) begin errors++; $display("FAIL br_discard got ir_en=%b exp 0", ir_en); end
        checks++; if (pc_en !== 1'b1 || pc_data !== 16'h2000) begin errors++; $display("FAIL br_target got en=%b data=%h exp 1 2000", pc_en, pc_data); end
        drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h4444);
        checks++; if (imem_addr !== 16'h2000) begin errors++; $display("FAIL br_next got addr=%h exp 2000", imem_addr); end
        drive(1'b1, 1'b1, 16'h3000, 1'b0, 16'h0);
        checks++; if (pc_en !== 1'b1 || pc_data !== 16'h3000 || ir_en !== 1'b0) begin errors++; $display("FAIL hold_branch got en=%b data=%h ir=%b exp 1 3000 0", pc_en, pc_data, ir_en); end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h3000) begin errors++; $display("FAIL hold_branch_req got req=%b addr=%h exp 1 3000", imem_req, imem_addr); end
    endtask

    task automatic test_wrap;
        drive(1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h5A5A);
        checks++; if (imem_addr !== 16'hFFFF || pc_data !== 16'h0000 || pc_en !== 1'b1) begin errors++; $display("FAIL wrap got addr=%h pc_en=%b pc_data=%h exp ffff 1 0000", imem_addr, pc_en, pc_data); end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next got addr=%h exp 0000", imem_addr); end
    endtask

    task automatic test_reset_mid;
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_pre_req got %b exp 1", imem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({imem_req, pc_en, ir_en} !== 3'b000) begin errors++; $display("FAIL mid_async got %b exp 000", {imem_req, pc_en, ir_en}); end
`ifdef FETCH_PERF_EN
        checks++; if (fetch_count !== 16'h0 || discard_count !== 16'h0) begin errors++; $display("FAIL perf_reset got %h %h exp 0 0", fetch_count, discard_count); end
`endif
        @(negedge clk); @(negedge clk); rst_n = 1'b1; #1;
        checks++; if ({imem_req, pc_en, ir_en} !== 3'b000) begin errors++; $display("FAIL mid_idle got %b exp 000", {imem_req, pc_en, ir_en}); end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (pc_en !== 1'b1 || pc_data !== 16'h0100) begin errors++; $display("FAIL mid_boot got en=%b data=%h exp 1 0100", pc_en, pc_data); end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL mid_req got req=%b addr=%h exp 1 0100", imem_req, imem_addr); end
    endtask

    // Transaction-level reference: a held word and a queued redirect.
    task automatic test_random;
        logic [15:0] exp_pc;
        logic [15:0] held[$];
        logic [15:0] redir[$];
        logic        s, bv, a, e_ir, e_pcen;
        logic [15:0] bt, rd, e_ird, e_pcd;
        exp_pc = 16'h0100;
        for (int n = 0; n < 600; n++) begin
            s  = ($urandom_range(0, 3) == 0);
            bv = ($urandom_range(0, 7) == 0);
            bt = 16'($urandom);
            rd = 16'($urandom);
            a  = (held.size() == 0) && ($urandom_range(0, 2) == 0);
            drive(s, bv, bt, a, rd);
            e_ir = 1'b0; e_pcen = 1'b0; e_ird = 16'h0; e_pcd = 16'h0;
            if (held.size() == 0) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_req n=%0d got req=%b addr=%h exp 1 %h", n, imem_req, imem_addr, exp_pc); end
                if (a) begin
                    if (bv || redir.size() != 0) begin
                        e_pcen = 1'b1; e_pcd = bv ? bt : redir[0];
                    end else if (s) begin
                        held.push_back(rd);
                    end else begin
                        e_ir = 1'b1; e_ird = rd; e_pcen = 1'b1; e_pcd = exp_pc + 16'd1;
                    end
                    redir.delete();
                end else if (bv) begin
                    redir.delete();
                    redir.push_back(bt);
                end
            end else begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_hold_req n=%0d got %b exp 0", n, imem_req); end
                if (bv) begin
                    e_pcen = 1'b1; e_pcd = bt; held.delete();
                end else if (!s) begin
                    e_ir = 1'b1; e_ird = held[0]; e_pcen = 1'b1; e_pcd = exp_pc + 16'd1; held.delete();
                end
            end
            checks++; if (ir_en !== e_ir || (e_ir && ir_data !== e_ird)) begin errors++; $display("FAIL rnd_ir n=%0d got en=%b data=%h exp en=%b data=%h", n, ir_en, ir_data, e_ir, e_ird); end
            checks++; if (pc_en !== e_pcen || (e_pcen && pc_data !== e_pcd)) begin errors++; $display("FAIL rnd_pc n=%0d got en=%b data=%h exp en=%b data=%h", n, pc_en, pc_data, e_pcen, e_pcd); end
            if (e_pcen) exp_pc = e_pcd;
        end
    endtask

    initial begin
        test_reset;
        test_zero_wait;
        test_wait3;
        test_stall;
        test_branch;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
